// File: rtl/rc5_key_sched_ctrl_if.sv
// Bundle between the RC5 key-schedule sequencer and its environment:
// cipher-control handshake, L-conversion handshake, and the S/L RAM ports.
interface rc5_key_sched_ctrl_if #(
  parameter int W = 32,
  parameter int T = 26,
  parameter int C = 4
);
  localparam int T_LEN = $clog2(T);
  localparam int C_LEN = $clog2(C);

  logic             start;
  logic             busy;
  logic             done;
  logic             lop_start;
  logic             lop_done;
  logic [T_LEN-1:0] s_addr;
  logic [W-1:0]     s_wdata;
  logic             s_we;
  logic [W-1:0]     s_rdata;
  logic [C_LEN-1:0] l_addr;
  logic [W-1:0]     l_wdata;
  logic             l_we;
  logic [W-1:0]     l_rdata;

  // Sequencer side.
  modport master (
    input  start, lop_done, s_rdata, l_rdata,
    output busy, done, lop_start, s_addr, s_wdata, s_we, l_addr, l_wdata, l_we
  );

  // Cipher control, L-conversion unit and RAMs.
  modport slave (
    output start, lop_done, s_rdata, l_rdata,
    input  busy, done, lop_start, s_addr, s_wdata, s_we, l_addr, l_wdata, l_we
  );
endinterface

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key-expansion sequencer: triggers the external key-to-L conversion,
// fills S with the P/Q progression, then runs the 3*max(T,C) mixing loop
// over the S and L RAMs (A/B mixing with data-dependent rotates).
module rc5_key_sched_ctrl #(
  parameter int           W = 32,
  parameter int           T = 26,
  parameter int           C = 4,
  parameter logic [W-1:0] P = 32'hB7E15163,
  parameter logic [W-1:0] Q = 32'h9E3779B9
) (
  input logic                clk,
  input logic                rst,
  rc5_key_sched_ctrl_if.master bus
);

  localparam int N      = 3 * ((T > C) ? T : C);
  localparam int T_LEN  = $clog2(T);
  localparam int C_LEN  = $clog2(C);
  localparam int K_LEN  = $clog2(N);
  localparam int SH_LEN = $clog2(W);

  localparam logic [T_LEN-1:0]  T_LAST = T_LEN'(T - 1);
  localparam logic [C_LEN-1:0]  C_LAST = C_LEN'(C - 1);
  localparam logic [K_LEN-1:0]  K_LAST = K_LEN'(N - 1);
  localparam logic [SH_LEN-1:0] ROT_A  = SH_LEN'(3);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_L = 3'd1,
    INIT_S = 3'd2,
    MIX_RD = 3'd3,
    MIX_S  = 3'd4,
    MIX_L  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Rotate left; only the low log2(W) bits of the amount matter.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SH_LEN-1:0] amt);
    logic [2*W-1:0] d;
    d = {x, x} << amt;
    return d[2*W-1:W];
  endfunction

  state_t           state_r, next_state_s;
  logic [T_LEN-1:0] i_r, i_s;
  logic [C_LEN-1:0] j_r, j_s;
  logic [K_LEN-1:0] k_r, k_s;
  logic [W-1:0]     a_r, a_s;
  logic [W-1:0]     b_r, b_s;
  logic [W-1:0]     lj_r, lj_s;
  logic [W-1:0]     acc_r, acc_s;
  logic             done_r, done_s;

  logic             busy_r, busy_s;
  logic             lop_start_r, lop_start_s;
  logic             s_we_r, s_we_s;
  logic             l_we_r, l_we_s;
  logic [T_LEN-1:0] s_addr_r, s_addr_s;
  logic [C_LEN-1:0] l_addr_r, l_addr_s;

  logic [W-1:0]     ab_sum_s;
  logic [W-1:0]     a_new_s;
  logic [W-1:0]     b_new_s;
  logic [W-1:0]     s_wdata_s;
  logic [W-1:0]     l_wdata_s;

  // Mixing datapath. In MIX_L, a_r already holds the freshly written A.
  always_comb begin
    ab_sum_s = a_r + b_r;
    a_new_s  = rotl(bus.s_rdata + ab_sum_s, ROT_A);
    b_new_s  = rotl(lj_r + ab_sum_s, ab_sum_s[SH_LEN-1:0]);
  end

  // Next-state and next-register values.
  always_comb begin
    next_state_s = state_r;
    i_s          = i_r;
    j_s          = j_r;
    k_s          = k_r;
    a_s          = a_r;
    b_s          = b_r;
    lj_s         = lj_r;
    acc_s        = acc_r;
    done_s       = done_r;
    lop_start_s  = 1'b0;
    case (state_r)
      IDLE: begin
        i_s = '0;
        j_s = '0;
        k_s = '0;
        a_s = '0;
        b_s = '0;
        if (bus.start) begin
          next_state_s = LOAD_L;
          done_s       = 1'b0;
          lop_start_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD_L: begin
        if (bus.lop_done) begin
          next_state_s = INIT_S;
          acc_s        = P;
          i_s          = '0;
        end else begin
          next_state_s = LOAD_L;
        end
      end
      INIT_S: begin
        acc_s = acc_r + Q;
        if (i_r == T_LAST) begin
          i_s          = '0;
          next_state_s = MIX_RD;
        end else begin
          i_s          = i_r + T_LEN'(1);
          next_state_s = INIT_S;
        end
      end
      MIX_RD: begin
        next_state_s = MIX_S;
      end
      MIX_S: begin
        a_s          = a_new_s;
        lj_s         = bus.l_rdata;
        next_state_s = MIX_L;
      end
      MIX_L: begin
        b_s = b_new_s;
        i_s = (i_r == T_LAST) ? '0 : i_r + T_LEN'(1);
        j_s = (j_r == C_LAST) ? '0 : j_r + C_LEN'(1);
        k_s = k_r + K_LEN'(1);
        if (k_r == K_LAST) begin
          next_state_s = DONE;
          done_s       = 1'b1;
        end else begin
          next_state_s = MIX_RD;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Port controls for the state being entered, so the registered outputs line up with it.
  always_comb begin
    busy_s   = 1'b0;
    s_we_s   = 1'b0;
    l_we_s   = 1'b0;
    s_addr_s = '0;
    l_addr_s = '0;
    case (next_state_s)
      LOAD_L: begin
        busy_s = 1'b1;
      end
      INIT_S: begin
        busy_s   = 1'b1;
        s_we_s   = 1'b1;
        s_addr_s = i_s;
      end
      MIX_RD: begin
        busy_s   = 1'b1;
        s_addr_s = i_s;
        l_addr_s = j_s;
      end
      MIX_S: begin
        busy_s   = 1'b1;
        s_we_s   = 1'b1;
        s_addr_s = i_s;
        l_addr_s = j_s;
      end
      MIX_L: begin
        busy_s   = 1'b1;
        l_we_s   = 1'b1;
        l_addr_s = j_s;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Write data: INIT_S streams the accumulator, the mix states drive the fresh A'/B'.
  always_comb begin
    s_wdata_s = '0;
    l_wdata_s = '0;
    case (state_r)
      INIT_S:  s_wdata_s = acc_r;
      MIX_S:   s_wdata_s = a_new_s;
      MIX_L:   l_wdata_s = b_new_s;
      default: s_wdata_s = '0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      lj_r    <= '0;
      acc_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      k_r     <= k_s;
      a_r     <= a_s;
      b_r     <= b_s;
      lj_r    <= lj_s;
      acc_r   <= acc_s;
      done_r  <= done_s;
    end
  end

  // Registered handshake, enables and addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      lop_start_r <= 1'b0;
      s_we_r      <= 1'b0;
      l_we_r      <= 1'b0;
      s_addr_r    <= '0;
      l_addr_r    <= '0;
    end else begin
      busy_r      <= busy_s;
      lop_start_r <= lop_start_s;
      s_we_r      <= s_we_s;
      l_we_r      <= l_we_s;
      s_addr_r    <= s_addr_s;
      l_addr_r    <= l_addr_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.lop_start = lop_start_r;
  assign bus.s_we      = s_we_r;
  assign bus.s_addr    = s_addr_r;
  assign bus.s_wdata   = s_wdata_s;
  assign bus.l_we      = l_we_r;
  assign bus.l_addr    = l_addr_r;
  assign bus.l_wdata   = l_wdata_s;

endmodule

// File: doc/rc5_key_sched_ctrl.md
# rc5_key_sched_ctrl

Sequencer for the complete RC5 key-expansion flow. It starts the external secret-key-to-L conversion unit and waits for it to finish. It then fills the S table with the P/Q magic-constant progression and runs the 3·max(T,C) mixing loop over the S and L word memories. It sits between the top-level cipher control (start/done) and the S and L RAMs, and owns both RAM ports except the L port during the L-load phase.

## Interface
- W, 32: word width in bits; rotations are taken mod W.
- T, 26: number of S words (2r+2).
- C, 4: number of L words.
- P, 32'hB7E15163: first S constant.
- Q, 32'h9E3779B9: S increment constant.
- Derived: N = 3·max(T,C); T_length = $clog2(T); C_length = $clog2(C).

- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  begin key expansion; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  key schedule complete; level, held until the next accepted start.
- lop_start  out  1  one-cycle start pulse to the L-conversion unit.
- lop_done  in  1  L-conversion finished (level, sampled on clk).
- s_addr  out  T_length  S RAM address.
- s_wdata  out  W  S RAM write data.
- s_we  out  1  S RAM write enable.
- s_rdata  in  W  S RAM read data; synchronous, valid the cycle after s_addr.
- l_addr  out  C_length  L RAM address.
- l_wdata  out  W  L RAM write data.
- l_we  out  1  L RAM write enable.
- l_rdata  in  W  L RAM read data; synchronous, 1-cycle latency.

## Operation
- States: IDLE, LOAD_L, INIT_S, MIX_RD, MIX_S, MIX_L, DONE.
- IDLE:
  - start=1 → LOAD_L.
  - Clears i, j, k, A, B, and done.
- LOAD_L:
  - lop_start=1 in the first cycle only.
  - l_we and s_we are held 0; the L port belongs to the conversion unit.
  - lop_done=1 → INIT_S.
- INIT_S:
  - Runs for T cycles, idx = 0..T-1.
  - s_we=1, s_addr=idx, s_wdata=acc. acc starts at P and gets +Q each cycle, mod 2^W.
  - After idx = T-1 → MIX_RD.
- MIX_RD: s_addr=i, l_addr=j; no writes.
- MIX_S:
  - Computes A' = rotl(s_rdata + A + B, 3).
  - s_we=1, s_wdata=A', s_addr=i. Registers A←A' and Lj←l_rdata.
- MIX_L:
  - Computes B' = rotl(Lj + A + B, (A+B) mod W), using the updated A and the old B.
  - l_we=1, l_wdata=B', l_addr=j. Registers B←B'.
  - Updates i←(i+1) mod T, j←(j+1) mod C, k←k+1.
  - If k was N-1 → DONE, else → MIX_RD.
- DONE:
  - done=1, busy=0. Moves to IDLE in the same cycle; done stays 1 until the next start is accepted.
- All sums are mod 2^W. Rotate amounts use only the low $clog2(W) bits.
- start while busy is ignored.
- lop_done already high on LOAD_L entry: leave LOAD_L after exactly one cycle (the lop_start cycle).

## Timing
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0 (busy, done, lop_start, s_we, l_we, addresses, wdata); A=B=i=j=k=0. Reset mid-operation aborts immediately; RAM contents are undefined afterwards.
- start accepted at edge n → LOAD_L at n+1, with lop_start high during cycle n+1.
- Latency from lop_done sampled high to done: T + 3N + 1 cycles.
  - INIT_S: T cycles. Mixing: 3 cycles per iteration.
  - With the defaults: 26 + 234 + 1 = 261.
- Write enables are single-cycle and registered; addresses and data are stable in the same cycle as the enable.
- The mixing loop performs exactly N S-writes and N L-writes.

## Test plan
- Reset: assert rst=0 mid-MIX → all outputs 0 within the same cycle. After release, state is IDLE and no write occurs until start.
- INIT_S values (defaults): s_we pulses at addr 0, 1, 25 carry 0xB7E15163, 0x5618CB1C, 0x2B4C3474. Exactly 26 consecutive writes.
- First mix iteration, L RAM all zero:
  - S[0] write = 0xBF0A8B1D.
  - L[0] write = 0xB7E15163 (rotate by 29).
- Counts: 78 s_we and 78 l_we pulses during mixing. Last S write at addr 25 (77 mod 26), last L write at addr 1 (77 mod 4). done rises 261 cycles after lop_done.
- Handshake:
  - lop_done held low 50 cycles → controller stays in LOAD_L with no RAM writes.
  - lop_done already high → INIT_S starts 1 cycle after lop_start.
- start pulses while busy → no restart, identical write trace. A second start after done → done clears and a full identical sequence repeats.
